// File: rtl/misao_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : misao_pkg
//  Description : Shared types and constants for the MISA-O fetch front end:
//                fetch FSM encoding, operand size limits and the link-width
//                nibble counts the decoder uses to drive opnd_len.
//  Revision    : 1.0 - initial release
// ============================================================================
package misao_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned OPND_MAX_NIB = 4;

    // Operand nibble counts per link width
    localparam logic [2:0] UL   = 3'd1;
    localparam logic [2:0] LK8  = 3'd2;
    localparam logic [2:0] LK16 = 3'd4;

    // Out-of-range lengths (0 and anything above the maximum) mean "maximum"
    function automatic logic [2:0] norm_opnd_len(input logic [2:0] len);
        return ((len == 3'd0) || (len > 3'(OPND_MAX_NIB))) ? 3'(OPND_MAX_NIB) : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/misao_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : misao_byte_fifo
//  Description : DEPTH x 8 synchronous prefetch FIFO with flush. A push into
//                a full FIFO is accepted only when a pop frees the slot in
//                the same cycle; flush wins over push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module misao_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_wr;
    logic             w_rd;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign w_rd = pop_i && !empty_o && !flush_i;
    assign w_wr = push_i && (!full_o || w_rd) && !flush_i;

    // Storage array; contents are only observed while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/misao_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : misao_fetch_unit
//  Description : Nibble-serial instruction fetch and operand collection for
//                the MISA-O core. Byte reads via req/ack, prefetch FIFO,
//                nibble stream with valid/ready, multi-nibble operand
//                assembly and PC redirect with flush.
//                Optional: `define MISAO_FETCH_PERF_EN builds the saturating
//                perf_stall / perf_flush counters (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module misao_fetch_unit
    import misao_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(2)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              nib_valid,
    output logic [3:0]        nib_data,
    output logic [ADDR_W-1:0] nib_pc,
    input  logic              nib_ready,
    input  logic              opnd_req,
    input  logic [2:0]        opnd_len,
    output logic              opnd_valid,
    output logic [15:0]       opnd_data,
    output logic              busy,
    output logic [31:0]       perf_stall,
    output logic [15:0]       perf_flush
);

    localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FIFO_CAP = CNT_W'(DEPTH);

    fetch_state_t      fstate_q, fstate_d;
    logic [ADDR_W-2:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-2:0] drop_addr_q, drop_addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       shift_q, shift_d;
    logic [15:0]       opnd_data_q, opnd_data_d;
    logic              opnd_valid_q, opnd_valid_d;

    logic              w_push, w_pop, w_take, w_can_req;
    logic [7:0]        w_fifo_rdata;
    logic              w_fifo_full, w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [3:0]        w_nib;

    misao_byte_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (mem_data),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Odd PC selects the high nibble; the byte leaves the FIFO with it
    assign w_nib      = pc_q[0] ? w_fifo_rdata[7:4] : w_fifo_rdata[3:0];
    assign nib_valid  = !w_fifo_empty && !busy_q;
    assign nib_data   = w_fifo_empty ? 4'h0 : w_nib;
    assign nib_pc     = pc_q;
    assign w_take     = !redirect_valid && (busy_q ? !w_fifo_empty : (nib_valid && nib_ready));
    assign w_pop      = w_take && pc_q[0];
    assign w_can_req  = (w_fifo_count < FIFO_CAP);
    assign w_push     = (fstate_q == F_REQ) && mem_ack && !redirect_valid
                        && (!w_fifo_full || w_pop);

    assign mem_req    = (fstate_q != F_IDLE);
    assign mem_addr   = (fstate_q == F_DROP) ? drop_addr_q : fetch_ptr_q;
    assign busy       = busy_q;
    assign opnd_valid = opnd_valid_q;
    assign opnd_data  = opnd_data_q;

    // Fetch FSM next state; a redirect always reloads the fetch pointer
    always_comb begin
        fstate_d    = fstate_q;
        fetch_ptr_d = fetch_ptr_q;
        drop_addr_d = drop_addr_q;
        case (fstate_q)
            F_IDLE: begin
                if (redirect_valid || w_can_req) begin
                    fstate_d = F_REQ;
                end
            end
            F_REQ: begin
                if (mem_ack) begin
                    fstate_d = F_IDLE;
                    if (!redirect_valid) begin
                        fetch_ptr_d = fetch_ptr_q + (ADDR_W - 1)'(1);
                    end
                end else if (redirect_valid) begin
                    fstate_d    = F_DROP;
                    drop_addr_d = fetch_ptr_q;
                end
            end
            F_DROP: begin
                if (mem_ack) begin
                    fstate_d = F_IDLE;
                end
            end
            default: fstate_d = F_IDLE;
        endcase
        if (redirect_valid) begin
            fetch_ptr_d = redirect_pc[ADDR_W-1:1];
        end
    end

    // PC and operand collection next state; redirect aborts collection
    always_comb begin
        pc_d         = pc_q;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        opnd_data_d  = opnd_data_q;
        opnd_valid_d = 1'b0;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            busy_d = 1'b0;
        end else begin
            if (w_take) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (!busy_q) begin
                if (opnd_req) begin
                    busy_d  = 1'b1;
                    cnt_d   = norm_opnd_len(opnd_len);
                    idx_d   = 2'd0;
                    shift_d = 16'h0000;
                end
            end else if (!w_fifo_empty) begin
                shift_d[{idx_q, 2'b00} +: 4] = w_nib;
                idx_d = idx_q + 2'd1;
                if (({1'b0, idx_q} + 3'd1) == cnt_q) begin
                    busy_d       = 1'b0;
                    opnd_data_d  = shift_d;
                    opnd_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate_q     <= F_IDLE;
            fetch_ptr_q  <= RESET_PC[ADDR_W-1:1];
            drop_addr_q  <= RESET_PC[ADDR_W-1:1];
            pc_q         <= RESET_PC;
            busy_q       <= 1'b0;
            cnt_q        <= 3'd0;
            idx_q        <= 2'd0;
            shift_q      <= 16'h0000;
            opnd_data_q  <= 16'h0000;
            opnd_valid_q <= 1'b0;
        end else begin
            fstate_q     <= fstate_d;
            fetch_ptr_q  <= fetch_ptr_d;
            drop_addr_q  <= drop_addr_d;
            pc_q         <= pc_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            opnd_data_q  <= opnd_data_d;
            opnd_valid_q <= opnd_valid_d;
        end
    end

`ifdef MISAO_FETCH_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    // Saturating stall and redirect counters; redirect cycles are not stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 16'd0;
        end else begin
            if (nib_ready && !nib_valid && !redirect_valid && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redirect_valid && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = 32'd0;
    assign perf_flush = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/misao_fetch_unit.md
# misao_fetch_unit

Parametrised nibble-serial instruction fetch and operand-collection front end for the MISA-O core. It issues byte reads to program memory through a req/ack handshake, buffers bytes in a prefetch FIFO, and presents a nibble stream to the decoder with valid/ready flow control. It assembles multi-nibble immediates (LDI, CFG and similar operands of 1–4 nibbles) into a single word, and redirects the stream on PC change. It replaces the single-byte, always-ready fetch path and sits between program memory and the core's decode stage.

## Interface
- ADDR_W, 16: nibble-address (PC) width; byte address is ADDR_W-1 bits.
- DEPTH, 4: prefetch FIFO depth in bytes; power of two, ≥2.
- RESET_PC, 16'h0002: nibble PC loaded at reset.
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  byte read request; held until mem_ack.
- mem_addr  out  ADDR_W-1  byte address, stable while mem_req is high.
- mem_ack  in  1  read complete; mem_data is valid in the same cycle.
- mem_data  in  8  read byte; low nibble is the even PC, high nibble the odd PC.
- redirect_valid  in  1  load a new PC and flush.
- redirect_pc  in  ADDR_W  new nibble PC.
- nib_valid  out  1  nib_data/nib_pc valid.
- nib_data  out  4  current nibble.
- nib_pc  out  ADDR_W  nibble address of nib_data.
- nib_ready  in  1  decoder consumes nibble.
- opnd_req  in  1  start operand collection.
- opnd_len  in  3  operand nibble count, 1..4; 0 and >4 are treated as 4.
- opnd_valid  out  1  one-cycle pulse: opnd_data complete.
- opnd_data  out  16  assembled operand, little-endian by nibble, zero-extended.
- busy  out  1  operand collection in progress.
- perf_stall  out  32  cycles with nib_ready=1 and nib_valid=0 (see Configuration).
- perf_flush  out  16  count of redirects (see Configuration).

## Operation
- Fetch FSM states: F_IDLE, F_REQ, F_DROP.
  - F_IDLE → F_REQ when FIFO free slots ≥1. Drive mem_req=1 with mem_addr=fetch_ptr.
  - F_REQ + mem_ack: push mem_data, fetch_ptr++, return to F_IDLE.
  - F_REQ + redirect without ack → F_DROP. Keep mem_req high at the old address; discard data on ack; then F_IDLE.
  - F_REQ + redirect with ack in the same cycle: data discarded, → F_IDLE.
- At most one request is outstanding. fetch_ptr wraps modulo 2^(ADDR_W-1).
- Nibble select: pc[0]=0 selects mem_data[3:0], pc[0]=1 selects mem_data[7:4]. A byte is popped when its high nibble is consumed.
- Odd redirect_pc: the first byte's low nibble is skipped and never presented.
- A handshake (nib_valid & nib_ready) advances pc by 1; pc wraps at 2^ADDR_W.
- Operand collection:
  - opnd_req sampled high with busy=0 → busy=1, count=opnd_len, index=0, shift register cleared.
  - If a nib handshake occurs in the same cycle, that nibble is the opcode. Collection starts from the following nibble.
  - While busy: nib_valid=0 to the decoder, and each available nibble is consumed internally (1 per cycle) into shift[index*4 +: 4].
  - After the last nibble: opnd_data updates and opnd_valid pulses in the next cycle, busy=0 in the same cycle.
  - opnd_req while busy is ignored.
- Redirect has priority over everything. In the cycle it is sampled: FIFO flushed, pc=redirect_pc, fetch_ptr=redirect_pc>>1, collection aborted (no opnd_valid, opnd_data unchanged), and any same-cycle nib handshake discarded.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC>>1, nib_valid=0, nib_data=0, nib_pc=RESET_PC, opnd_valid=0, opnd_data=0, busy=0, perf_*=0. FSM is in F_IDLE.
- First mem_req occurs in the first clock after rst deasserts.
- Redirect sampled at cycle T: mem_req at T+1, or once F_DROP resolves. With mem_ack at T+1, nib_valid=1 at T+2.
- Sustained throughput with zero-wait memory is 1 nibble/cycle. FIFO full (DEPTH bytes) → no new request until a pop.
- Simultaneous push and pop on a full FIFO is allowed only in the cycle the pop frees the slot. A request is never issued to a full FIFO.
- Operand of N nibbles already buffered: busy for N cycles, opnd_valid on cycle N+1.
- Reset asserted mid-transfer: all state returns to reset values immediately; a late mem_ack after reset is ignored because FSM=F_IDLE.

## Configuration
- MISAO_FETCH_PERF_EN defined: perf_stall and perf_flush count as specified, saturating at all-ones. A redirect does not count as a stall.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- misao_pkg holds:
  - fetch_state_t enum (F_IDLE, F_REQ, F_DROP);
  - OPND_MAX_NIB=4;
  - the link-width nibble-count constants (UL=1, LK8=2, LK16=4) used by the decoder to drive opnd_len.
- One sub-module, misao_byte_fifo: parametrised DEPTH×8 synchronous FIFO with push, pop, flush, full, empty and count.

## Test plan
- Reset, zero-wait memory with bytes 0x21,0x43: nib_data sequence 1,2,3,4 with nib_pc 2,3,4,5 and nib_ready=1, one per cycle from the third cycle.
- redirect_pc=0x0007, byte 3 = 0xA5: the first nibble presented is 0xA with nib_pc=7; the low nibble 0x5 is never presented.
- Opcode handshake with opnd_req=1, opnd_len=4, following nibbles 0xD,0xC,0xB,0xA: opnd_valid pulse with opnd_data=0xABCD; nib_valid=0 while busy.
- Redirect while in F_REQ with mem_ack delayed 3 cycles: the old byte is dropped, and the next mem_req carries the new address. No stale nibble is presented.
- DEPTH=4, nib_ready=0: exactly 4 requests, then mem_req stays low. One byte popped → exactly one new request.
- Redirect during opnd_len=3 collection after 2 nibbles: no opnd_valid, busy=0 next cycle, and opnd_data keeps its previous value.
